// File: rtl/vending_fsm_param.sv
// vending_fsm_param
//   Coin-operated vending controller. Coins are counted in half-units and
//   accumulate as credit while the controller is in IDLE. When the credit
//   reaches the item price, it issues one vend pulse. Any excess becomes change.
//   A cancel request refunds the whole credit instead. Change and refunds are
//   paid out one half-unit per cycle in the CHANGE state.
//
// Parameters
//   PRICE_HALVES  item price in half-units (5 = 2.5)
//   CREDIT_W      width of the credit and change counters; must satisfy
//                 2**CREDIT_W > PRICE_HALVES + 6
//   CNT_W         width of the sold-item counter (wraps)
//
// Ports
//   sys_clk        rising-edge clock
//   sys_rst        synchronous active-high reset
//   pi_money_half  half-unit coin this cycle (1 half-unit)
//   pi_money_one   one-unit coin this cycle (2 half-units)
//   pi_money_two   two-unit coin this cycle (4 half-units)
//   pi_cancel      refund request
//   po_cola        registered one-cycle vend pulse
//   po_money       registered pulse, one half-unit of change per high cycle
//   po_busy        high while paying out change (state is not IDLE)
//   po_credit      accumulated credit in half-units
//   po_sold_cnt    items vended since reset, wraps modulo 2**CNT_W
module vending_fsm_param #(
  parameter int PRICE_HALVES = 5,
  parameter int CREDIT_W     = 4,
  parameter int CNT_W        = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                pi_money_half,
  input  logic                pi_money_one,
  input  logic                pi_money_two,
  input  logic                pi_cancel,
  output logic                po_cola,
  output logic                po_money,
  output logic                po_busy,
  output logic [CREDIT_W-1:0] po_credit,
  output logic [CNT_W-1:0]    po_sold_cnt
);

  typedef enum logic {
    IDLE   = 1'b0,
    CHANGE = 1'b1
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_HALVES);

  state_t              state;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] chg;
  logic [CREDIT_W-1:0] sum;

  // Value of the coins presented this cycle. Simultaneous coins all count.
  // The parameter rule on CREDIT_W makes sure credit + 7 cannot overflow.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic half,
                                                     input logic one,
                                                     input logic two);
    logic [CREDIT_W-1:0] v;
    v = '0;
    if (half) v = v + CREDIT_W'(1);
    if (one)  v = v + CREDIT_W'(2);
    if (two)  v = v + CREDIT_W'(4);
    return v;
  endfunction

  always_comb begin
    sum = credit + coin_value(pi_money_half, pi_money_one, pi_money_two);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      credit      <= '0;
      chg         <= '0;
      po_cola     <= 1'b0;
      po_money    <= 1'b0;
      po_sold_cnt <= '0;
    end else begin
      po_cola  <= 1'b0;
      po_money <= 1'b0;
      case (state)
        IDLE: begin
          // Cancel wins over a vend in the same cycle. Cancel with nothing
          // inserted leaves everything as it is.
          if (pi_cancel) begin
            if (sum != '0) begin
              credit <= '0;
              chg    <= sum;
              state  <= CHANGE;
            end
          end else if (sum >= PRICE) begin
            po_cola     <= 1'b1;
            credit      <= '0;
            chg         <= sum - PRICE;
            po_sold_cnt <= po_sold_cnt + CNT_W'(1);
            state       <= (sum != PRICE) ? CHANGE : IDLE;
          end else begin
            credit <= sum;
          end
        end
        CHANGE: begin
          // Coins and cancel are ignored while paying out.
          po_money <= 1'b1;
          chg      <= chg - CREDIT_W'(1);
          if (chg == CREDIT_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign po_busy   = (state == CHANGE);
  assign po_credit = credit;

endmodule

// File: tb/tb_vending_fsm_param.sv
module tb_vending_fsm_param;

  localparam int PRICE    = 5;
  localparam int CREDIT_W = 4;
  localparam int CNT_W    = 3;

  logic                sys_clk = 1'b0;
  logic                sys_rst = 1'b0;
  logic                pi_money_half = 1'b0;
  logic                pi_money_one  = 1'b0;
  logic                pi_money_two  = 1'b0;
  logic                pi_cancel     = 1'b0;
  logic                po_cola;
  logic                po_money;
  logic                po_busy;
  logic [CREDIT_W-1:0] po_credit;
  logic [CNT_W-1:0]    po_sold_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: credit, change still owed, items sold.
  int m_credit = 0;
  int m_owed   = 0;
  int m_sold   = 0;
  int m_cola   = 0;
  int m_money  = 0;

  vending_fsm_param #(
    .PRICE_HALVES(PRICE),
    .CREDIT_W    (CREDIT_W),
    .CNT_W       (CNT_W)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .pi_money_half(pi_money_half),
    .pi_money_one (pi_money_one),
    .pi_money_two (pi_money_two),
    .pi_cancel    (pi_cancel),
    .po_cola      (po_cola),
    .po_money     (po_money),
    .po_busy      (po_busy),
    .po_credit    (po_credit),
    .po_sold_cnt  (po_sold_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge, from the inputs presented for it.
  always @(posedge sys_clk) begin
    int s;
    m_cola  = 0;
    m_money = 0;
    if (sys_rst) begin
      m_credit = 0;
      m_owed   = 0;
      m_sold   = 0;
    end else if (m_owed > 0) begin
      m_money = 1;
      m_owed  = m_owed - 1;
    end else begin
      s = m_credit + int'(pi_money_half) + 2 * int'(pi_money_one) + 4 * int'(pi_money_two);
      if (pi_cancel) begin
        if (s > 0) begin
          m_owed   = s;
          m_credit = 0;
        end
      end else if (s >= PRICE) begin
        m_cola   = 1;
        m_credit = 0;
        m_owed   = s - PRICE;
        m_sold   = (m_sold + 1) % (1 << CNT_W);
      end else begin
        m_credit = s;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("model_cola",   32'(po_cola),     32'(m_cola));
      chk("model_money",  32'(po_money),    32'(m_money));
      chk("model_busy",   32'(po_busy),     32'(m_owed > 0));
      chk("model_credit", 32'(po_credit),   32'(m_credit));
      chk("model_sold",   32'(po_sold_cnt), 32'(m_sold));
      chk("cola_money_exclusive", 32'(po_cola & po_money), 32'd0);
    end
  end

  // Present one set of inputs across one rising edge; returns at the next falling edge.
  task automatic step(input logic h, input logic o, input logic t,
                      input logic c, input logic r);
    pi_money_half = h;
    pi_money_one  = o;
    pi_money_two  = t;
    pi_cancel     = c;
    sys_rst       = r;
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Directed mixed vectors {half, one, two, cancel}, checked by the model.
  logic [3:0] vec [0:15] = '{4'b1000, 4'b0100, 4'b0101, 4'b0000, 4'b0010,
                             4'b1010, 4'b0000, 4'b0000, 4'b1110, 4'b0001,
                             4'b1000, 4'b1000, 4'b0011, 4'b0000, 4'b0000,
                             4'b0000};

  initial begin
    @(negedge sys_clk);
    // Reset; coins present during reset must be ignored.
    step(0, 0, 1, 0, 1);
    chk_en = 1'b1;
    chk("reset_credit", 32'(po_credit), 32'd0);
    chk("reset_busy",   32'(po_busy),   32'd0);
    chk("reset_sold",   32'(po_sold_cnt), 32'd0);
    chk("reset_cola",   32'(po_cola),   32'd0);

    // Five half-unit coins.
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 0, 0);
      chk("half_credit", 32'(po_credit), 32'(i));
    end
    step(1, 0, 0, 0, 0);
    chk("half5_cola",   32'(po_cola),   32'd1);
    chk("half5_credit", 32'(po_credit), 32'd0);
    chk("half5_money",  32'(po_money),  32'd0);
    idle(1);
    chk("half5_cola_off", 32'(po_cola), 32'd0);
    chk("half5_sold",     32'(po_sold_cnt), 32'd1);

    // Credit 4, then a two-unit coin: vend plus 3 change pulses.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("c4_credit", 32'(po_credit), 32'd4);
    step(0, 0, 1, 0, 0);
    chk("k_cola",  32'(po_cola),  32'd1);
    chk("k_busy",  32'(po_busy),  32'd1);
    chk("k_money", 32'(po_money), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("k1_money", 32'(po_money), 32'd1);
    chk("k1_busy",  32'(po_busy),  32'd1);
    step(0, 0, 0, 0, 0);
    chk("k2_money", 32'(po_money), 32'd1);
    chk("k2_busy",  32'(po_busy),  32'd1);
    step(0, 0, 0, 0, 0);
    chk("k3_money", 32'(po_money), 32'd1);
    chk("k3_busy",  32'(po_busy),  32'd0);
    step(0, 0, 0, 0, 0);
    chk("k4_money",  32'(po_money),  32'd0);
    chk("k4_credit", 32'(po_credit), 32'd0);
    chk("k4_sold",   32'(po_sold_cnt), 32'd2);

    // All three coins at once: sum 7, vend plus 2 change pulses.
    step(1, 1, 1, 0, 0);
    chk("all3_cola", 32'(po_cola), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("all3_m1", 32'(po_money), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("all3_m2", 32'(po_money), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("all3_m3", 32'(po_money), 32'd0);
    chk("all3_sold", 32'(po_sold_cnt), 32'd3);

    // Credit 3, cancel with a one-unit coin: refund 5, no vend; coins during refund ignored.
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("c3_credit", 32'(po_credit), 32'd3);
    step(0, 1, 0, 1, 0);
    chk("cancel_cola", 32'(po_cola), 32'd0);
    chk("cancel_busy", 32'(po_busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, i[0], 0);
      chk("refund_pulse", 32'(po_money), 32'd1);
    end
    chk("refund_busy_end", 32'(po_busy), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("refund_after", 32'(po_money), 32'd0);
    chk("refund_credit", 32'(po_credit), 32'd0);
    chk("refund_sold", 32'(po_sold_cnt), 32'd3);

    // Cancel with nothing inserted does nothing.
    step(0, 0, 0, 1, 0);
    chk("cancel0_busy", 32'(po_busy), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("cancel0_money", 32'(po_money), 32'd0);

    // Reset on the 2nd refund pulse aborts the refund.
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("abort_p1", 32'(po_money), 32'd1);
    step(1, 0, 0, 0, 1);
    chk("abort_money", 32'(po_money), 32'd0);
    chk("abort_busy",  32'(po_busy),  32'd0);
    chk("abort_sold",  32'(po_sold_cnt), 32'd0);
    chk("abort_credit", 32'(po_credit), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("abort_money_next", 32'(po_money), 32'd0);

    // Sold counter wraps after 2**CNT_W vends.
    for (int i = 1; i <= 7; i++) step(1, 0, 1, 0, 0);
    chk("wrap_sold7", 32'(po_sold_cnt), 32'd7);
    step(1, 0, 1, 0, 0);
    chk("wrap_sold0", 32'(po_sold_cnt), 32'd0);
    chk("wrap_cola",  32'(po_cola), 32'd1);

    // Mixed vectors, checked only by the model.
    for (int i = 0; i < 16; i++) step(vec[i][3], vec[i][2], vec[i][1], vec[i][0], 0);
    idle(8);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
